// File: rtl/mult_cdb_buffer.sv
// rtl/mult_cdb_buffer.sv - completion FIFO between the pipelined multiplier and the CDB, with issue credits and squash drop
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module mult_cdb_buffer #(
    parameter int DEPTH      = 4,
    parameter int PIPE_DEPTH = 8
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        issue_valid,
    output logic                        issue_ready,
    input  logic                        mult_done,
    input  logic [63:0]                 mult_product,
    input  logic [`ROB_TAG_LEN-1:0]     mult_tag,
    output logic                        cdb_valid,
    output logic [63:0]                 cdb_value,
    output logic [`ROB_TAG_LEN-1:0]     cdb_tag,
    input  logic                        cdb_grant,
    input  logic                        squash,
    output logic [$clog2(DEPTH+1)-1:0]  count,
    output logic                        overflow_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 1 || PIPE_DEPTH < 1) begin : g_bad_param
        $error("mult_cdb_buffer: DEPTH and PIPE_DEPTH must be at least 1");
    end

    logic [63:0]             value_q [DEPTH];
    logic [`ROB_TAG_LEN-1:0] tag_q   [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          err_q, err_d;

    logic accept, pop, push_req, push, full, underflow;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits depend only on registered state, so a grant frees a slot one cycle later.
    assign issue_ready = ({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);
    assign cdb_valid   = (count_q != '0);
    assign cdb_value   = value_q[head_q];
    assign cdb_tag     = tag_q[head_q];
    assign count       = count_q;
    assign overflow_err = err_q;

    assign accept    = issue_valid & issue_ready;
    assign pop       = cdb_valid & cdb_grant & ~squash;
    assign push_req  = mult_done & ~squash & (drop_q == '0);
    assign full      = (count_q == CW'(DEPTH)) & ~pop;
    assign push      = push_req & ~full;
    assign underflow = mult_done & (inflight_q == '0);

    always_comb begin
        inflight_d = inflight_q;
        if (accept) begin
            inflight_d = inflight_d + 1'b1;
        end
        // A stray done with nothing in flight is flagged, not allowed to wrap the counter.
        if (mult_done && inflight_d != '0) begin
            inflight_d = inflight_d - 1'b1;
        end

        head_d  = pop  ? ptr_inc(head_q) : head_q;
        tail_d  = push ? ptr_inc(tail_q) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        drop_d  = drop_q;
        if (mult_done && drop_q != '0) begin
            drop_d = drop_q - 1'b1;
        end
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            drop_d  = inflight_d;
        end

        err_d = err_q | (push_req & full) | underflow;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            value_q[tail_q] <= mult_product;
            tag_q[tail_q]   <= mult_tag;
        end
    end

endmodule

// File: tb/tb_mult_cdb_buffer.sv
// tb/tb_mult_cdb_buffer.sv - directed self-checking bench for mult_cdb_buffer
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module tb_mult_cdb_buffer;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    issue_valid;
    logic                    issue_ready;
    logic                    mult_done;
    logic [63:0]             mult_product;
    logic [`ROB_TAG_LEN-1:0] mult_tag;
    logic                    cdb_valid;
    logic [63:0]             cdb_value;
    logic [`ROB_TAG_LEN-1:0] cdb_tag;
    logic                    cdb_grant;
    logic                    squash;
    logic [2:0]              count;
    logic                    overflow_err;

    int checks   = 0;
    int failures = 0;

    mult_cdb_buffer #(.DEPTH(4), .PIPE_DEPTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .mult_done    (mult_done),
        .mult_product (mult_product),
        .mult_tag     (mult_tag),
        .cdb_valid    (cdb_valid),
        .cdb_value    (cdb_value),
        .cdb_tag      (cdb_tag),
        .cdb_grant    (cdb_grant),
        .squash       (squash),
        .count        (count),
        .overflow_err (overflow_err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid  = 1'b0;
        mult_done    = 1'b0;
        mult_product = '0;
        mult_tag     = '0;
        cdb_grant    = 1'b0;
        squash       = 1'b0;
    endtask

    task automatic done_pulse(input logic [63:0] p, input logic [`ROB_TAG_LEN-1:0] t);
        mult_done    = 1'b1;
        mult_product = p;
        mult_tag     = t;
        tick();
        mult_done    = 1'b0;
    endtask

    task automatic grant_one();
        cdb_grant = 1'b1;
        tick();
        cdb_grant = 1'b0;
    endtask

    initial begin
        // Reset wins over active inputs
        idle_inputs();
        reset       = 1'b1;
        issue_valid = 1'b1;
        mult_done   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        idle_inputs();
        check_eq("rst_cdb_valid", cdb_valid, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_issue_ready", issue_ready, 1);
        check_eq("rst_err", overflow_err, 0);

        // Single op: 8-cycle latency, product lands the cycle after done
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        mult_done    = 1'b1;
        mult_product = 64'h2A;
        mult_tag     = 5;
        #2;
        check_eq("single_no_bypass", cdb_valid, 0);
        tick();
        mult_done = 1'b0;
        check_eq("single_valid", cdb_valid, 1);
        check_eq("single_value", cdb_value, 64'h2A);
        check_eq("single_tag", cdb_tag, 5);
        check_eq("single_count", count, 1);
        grant_one();
        check_eq("single_pop_count", count, 0);
        check_eq("single_pop_valid", cdb_valid, 0);

        // Credit exhaustion
        issue_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("credit_ready_before", issue_ready, 1);
            tick();
        end
        check_eq("credit_exhausted", issue_ready, 0);
        tick();
        issue_valid = 1'b0;
        check_eq("credit_ignored_issue", issue_ready, 0);
        for (int i = 1; i <= 4; i++) done_pulse(64'h100 + 64'(i), 6'(i));
        check_eq("credit_count4", count, 4);
        check_eq("credit_ready_full", issue_ready, 0);
        check_eq("credit_order_1", cdb_tag, 1);
        check_eq("credit_value_1", cdb_value, 64'h101);
        grant_one();
        check_eq("credit_ready_after_pop", issue_ready, 1);
        check_eq("credit_order_2", cdb_tag, 2);
        grant_one();
        check_eq("credit_order_3", cdb_tag, 3);
        check_eq("credit_count2", count, 2);

        // Simultaneous push and pop keeps count and FIFO order
        issue_valid = 1'b1;
        tick();
        issue_valid  = 1'b0;
        cdb_grant    = 1'b1;
        mult_done    = 1'b1;
        mult_product = 64'h777;
        mult_tag     = 7;
        tick();
        idle_inputs();
        check_eq("pp_count", count, 2);
        check_eq("pp_head", cdb_tag, 4);
        grant_one();
        check_eq("pp_tail_tag", cdb_tag, 7);
        check_eq("pp_tail_value", cdb_value, 64'h777);
        grant_one();
        check_eq("pp_empty", count, 0);

        // Squash: 1 buffered, 2 in flight, 1 more accepted in the squash cycle
        issue_valid = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        issue_valid = 1'b0;
        done_pulse(64'hA, 10);
        check_eq("sq_pre_count", count, 1);
        squash      = 1'b1;
        issue_valid = 1'b1;
        cdb_grant   = 1'b1;
        tick();
        idle_inputs();
        check_eq("sq_count", count, 0);
        check_eq("sq_valid", cdb_valid, 0);
        check_eq("sq_ready", issue_ready, 1);
        for (int i = 0; i < 3; i++) begin
            done_pulse(64'hDEAD, 6'(11 + i));
            check_eq("sq_dropped", count, 0);
        end
        check_eq("sq_ready_all_back", issue_ready, 1);
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        done_pulse(64'h14, 20);
        check_eq("sq_post_count", count, 1);
        check_eq("sq_post_tag", cdb_tag, 20);
        check_eq("sq_err", overflow_err, 0);
        grant_one();

        // Underflow sets the sticky error
        done_pulse(64'h1E, 30);
        check_eq("err_set", overflow_err, 1);
        grant_one();
        tick();
        check_eq("err_sticky", overflow_err, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("err_cleared", overflow_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
